// File: rtl/lector_contadores.sv
// rtl/lector_contadores.sv - sweeps four output-FIFO counters through a req/idx/valid responder port.
// Optional LECTOR_TOTAL_EN adds a registered 7-bit sum of the captured counts.
module lector_contadores #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       start,
  input  logic       valid_in,
  input  logic [4:0] data_in,
  output logic       req,
  output logic [1:0] idx,
  output logic [4:0] cuenta_0,
  output logic [4:0] cuenta_1,
  output logic [4:0] cuenta_2,
  output logic [4:0] cuenta_3,
  output logic       busy,
  output logic       done,
`ifdef LECTOR_TOTAL_EN
  output logic [6:0] total,
`endif
  output logic       timeout_err
);

  localparam logic [7:0] TimeoutW = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic       req_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic [1:0] idx_q;
  logic [7:0] wait_q;
  logic [4:0] cuenta_q [4];

  logic       decide_d;
  logic [4:0] cap_val_d;

  // A valid answer wins over a timeout landing on the same cycle.
  always_comb begin
    decide_d  = (state_q == REQ) && (valid_in || (wait_q == TimeoutW));
    cap_val_d = valid_in ? data_in : 5'd0;
  end

`ifdef LECTOR_TOTAL_EN
  logic [6:0] total_q;
  logic [6:0] total_d;

  // Indices 0..2 are final when index 3 decides, so the sum lands in the DONE cycle.
  always_comb begin
    total_d = 7'(cuenta_q[0]) + 7'(cuenta_q[1]) + 7'(cuenta_q[2]) + 7'(cap_val_d);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      total_q <= 7'd0;
    end else if (decide_d && (idx_q == 2'd3)) begin
      total_q <= total_d;
    end
  end

  assign total = total_q;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= 2'd0;
      wait_q      <= 8'd0;
      cuenta_q[0] <= 5'd0;
      cuenta_q[1] <= 5'd0;
      cuenta_q[2] <= 5'd0;
      cuenta_q[3] <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            idx_q   <= 2'd0;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
          end
        end
        REQ: begin
          if (decide_d) begin
            cuenta_q[idx_q] <= cap_val_d;
            wait_q          <= 8'd0;
            if (!valid_in) begin
              err_q <= 1'b1;
            end
            if (idx_q == 2'd3) begin
              state_q <= DONE;
              req_q   <= 1'b0;
              idx_q   <= 2'd0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= 2'd0;
          wait_q  <= 8'd0;
        end
      endcase
    end
  end

  assign req         = req_q;
  assign idx         = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;
  assign cuenta_0    = cuenta_q[0];
  assign cuenta_1    = cuenta_q[1];
  assign cuenta_2    = cuenta_q[2];
  assign cuenta_3    = cuenta_q[3];

endmodule

// File: tb/tb_lector_contadores.sv
// tb/tb_lector_contadores.sv - randomized responder plus sweep-level reference model for lector_contadores.
module tb_lector_contadores;

  localparam int TO = 15;

  logic       clk;
  logic       rst_l;
  logic       start;
  logic       valid_in;
  logic [4:0] data_in;
  logic       req;
  logic [1:0] idx;
  logic [4:0] cuenta_0, cuenta_1, cuenta_2, cuenta_3;
  logic       busy;
  logic       done;
  logic       timeout_err;
`ifdef LECTOR_TOTAL_EN
  logic [6:0] total;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Responder configuration: value served per index, and cycles it withholds valid.
  logic [4:0] vals [4];
  int         dly  [4];

  lector_contadores #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_l(rst_l),
    .start(start),
    .valid_in(valid_in),
    .data_in(data_in),
    .req(req),
    .idx(idx),
    .cuenta_0(cuenta_0),
    .cuenta_1(cuenta_1),
    .cuenta_2(cuenta_2),
    .cuenta_3(cuenta_3),
    .busy(busy),
    .done(done),
`ifdef LECTOR_TOTAL_EN
    .total(total),
`endif
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder: counts cycles an index has been requested; outside req it drives noise.
  initial begin
    int   rcnt;
    logic prev_req;
    logic [1:0] prev_idx;
    rcnt = 0;
    prev_req = 1'b0;
    prev_idx = 2'd0;
    valid_in = 1'b0;
    data_in  = 5'd0;
    forever begin
      @(negedge clk);
      if (req) begin
        if (prev_req && idx == prev_idx) rcnt++;
        else rcnt = 0;
        valid_in = (rcnt >= dly[idx]);
        data_in  = valid_in ? vals[idx] : 5'($urandom);
      end else begin
        rcnt     = 0;
        valid_in = 1'($urandom);
        data_in  = 5'($urandom);
      end
      prev_req = req;
      prev_idx = idx;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] cuentas();
    return {cuenta_3, cuenta_2, cuenta_1, cuenta_0};
  endfunction

  // Runs one sweep and compares it with the sweep predicted from vals/dly.
  task automatic run_sweep(input string name, input bit restart);
    int         lat, cyc, done_cyc, ndone, req_cycles, badidx, lastidx, nseq;
    bit         seen_done, exp_err;
    logic [19:0] exp_c;
    logic [7:0] seqp;
    int         sum;
    lat = 1;
    exp_err = 1'b0;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (dly[i] <= TO) begin
        lat += dly[i] + 1;
        exp_c[i*5 +: 5] = vals[i];
        sum += vals[i];
      end else begin
        lat += TO + 1;
        exp_c[i*5 +: 5] = 5'd0;
        exp_err = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; done_cyc = 0; ndone = 0; req_cycles = 0; badidx = 0;
    lastidx = -1; nseq = 0; seqp = 8'd0; seen_done = 1'b0;
    while (cyc <= 400) begin
      start = (restart && cyc == 2);
      if (done) begin
        ndone++;
        if (!seen_done) done_cyc = cyc;
        seen_done = 1'b1;
      end
      if (req) begin
        req_cycles++;
        if (!busy) badidx++;
        if (int'(idx) != lastidx) begin
          seqp = {seqp[5:0], idx};
          nseq++;
        end
        lastidx = int'(idx);
      end else if (idx != 2'd0) begin
        badidx++;
      end
      if (seen_done && cyc > done_cyc + 2) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({name, "_done_cycle"}, done_cyc, lat);
    check({name, "_done_count"}, ndone, 1);
    check({name, "_req_cycles"}, req_cycles, lat - 1);
    check({name, "_idx_seq"}, {nseq[23:0], seqp}, {24'd4, 8'h1B});
    check({name, "_idle_idx_busy"}, badidx, 0);
    check({name, "_busy_after"}, busy, 1'b0);
    check({name, "_cuentas"}, cuentas(), exp_c);
    check({name, "_timeout_err"}, timeout_err, exp_err);
`ifdef LECTOR_TOTAL_EN
    check({name, "_total"}, total, sum);
`endif
    repeat (3 + $urandom_range(0, 4)) @(negedge clk);
    check({name, "_cuentas_hold"}, cuentas(), exp_c);
  endtask

  initial begin
    rst_l = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vals[i] = 5'd0;
      dly[i]  = 0;
    end
    repeat (2) @(negedge clk);
    check("reset_outputs", {req, idx, busy, done, timeout_err}, 5'd0);
    check("reset_cuentas", cuentas(), 20'd0);
`ifdef LECTOR_TOTAL_EN
    check("reset_total", total, 7'd0);
`endif
    rst_l = 1'b1;

    vals[0] = 5'd3; vals[1] = 5'd7; vals[2] = 5'd0; vals[3] = 5'd31;
    run_sweep("basic", 1'b0);

    vals[0] = 5'd9; vals[1] = 5'd21; vals[2] = 5'd4; vals[3] = 5'd17;
    dly[1] = 1000;
    run_sweep("timeout_idx1", 1'b0);

    for (int i = 0; i < 4; i++) dly[i] = 3;
    vals[1] = 5'd12;
    run_sweep("delay3", 1'b0);

    for (int i = 0; i < 4; i++) dly[i] = 0;
    vals[0] = 5'd1; vals[1] = 5'd2; vals[2] = 5'd30; vals[3] = 5'd5;
    run_sweep("restart_ignored", 1'b1);

    // Reset mid-sweep: outputs clear immediately and the sweep never finishes.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    check("midreset_outputs", {req, idx, busy, done, timeout_err}, 5'd0);
    check("midreset_cuentas", cuentas(), 20'd0);
    begin
      int seen;
      seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (done || req) seen++;
      end
      rst_l = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (done || req) seen++;
      end
      check("midreset_no_done", seen, 0);
    end

    vals[0] = 5'd11; vals[1] = 5'd22; vals[2] = 5'd6; vals[3] = 5'd19;
    run_sweep("after_reset", 1'b0);

    for (int i = 0; i < 4; i++) vals[i] = 5'd31;
    run_sweep("all31", 1'b0);
    for (int i = 0; i < 4; i++) vals[i] = 5'd0;
    run_sweep("all0", 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        vals[i] = 5'($urandom);
        case ($urandom_range(0, 7))
          0: dly[i] = TO;
          1: dly[i] = TO + 1;
          2: dly[i] = 40;
          default: dly[i] = $urandom_range(0, 4);
        endcase
      end
      run_sweep("random", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
